// File: rtl/instr_align_buffer_pkg.sv
// Shared constants and types for the fetch realignment buffer.
// Bus widths, polarity constants and the compressed-opcode mask live here.
package instr_align_buffer_pkg;

  localparam int XLEN         = 64;
  localparam int ADDR         = 32;
  localparam int WIN_HW       = 8;
  localparam int FETCH_HW     = 4;
  localparam int HW_PER_FETCH = FETCH_HW;

  localparam logic [ADDR-1:0] PC_RESET_ADDR   = 32'h8000_0000;
  localparam logic [XLEN-1:0] ZERO            = '0;
  localparam logic            CANCEL_INSTR    = 1'b1;
  localparam logic            IS_CINSTR       = 1'b1;
  localparam logic            HOLD            = 1'b1;
  localparam logic [1:0]      CINSTR_OPC_MASK = 2'b11;

  typedef logic [15:0] hw_t;
  typedef logic [3:0]  cnt_t;   // 0..WIN_HW halfwords

endpackage

// File: rtl/instr_align_buffer_len_dec.sv
// Instruction length decoder: a halfword whose low opcode bits are not 2'b11
// starts a 16-bit (compressed) instruction.
module instr_len_dec
  import instr_align_buffer_pkg::*;
(
  input  hw_t  hw_i,
  output logic is_cinstr_o
);

  assign is_cinstr_o = (hw_i[1:0] != CINSTR_OPC_MASK);

endmodule

// File: rtl/instr_align_buffer.sv
// Fetch-side realignment buffer: sliding halfword window that turns 8-byte
// aligned fetch words into a primary/aux instruction pair for IF/ID.
module instr_align_buffer
  import instr_align_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_data,
  output logic            fetch_ready,
  input  logic            redirect,
  input  logic [ADDR-1:0] redirect_pc,
  input  logic            hold,
  output logic [ADDR-1:0] instr_addr_if,
  output logic [XLEN-1:0] ifu_data_if,
  output logic            is_cinstr_if,
  output logic            is_cinstr_if_aux,
  output logic            cancel_instr_if,
  output logic            cancel_instr_if_aux
);

  localparam int WIN_W = WIN_HW * 16;

  logic [WIN_W-1:0] win_q, win_d;   // halfword 0 in [15:0]
  cnt_t             cnt_q, cnt_d;
  logic [ADDR-1:0]  pc_q, pc_d;
  logic [1:0]       drop_q, drop_d;
  // Suppresses compressed flags on the zeroed window straight out of reset.
  logic             filled_q, filled_d;

  logic prim_c, aux_c;
  hw_t  aux_hw;
  cnt_t p_len, a_len, k, rem;
  logic cancel, cancel_aux, accept;

  instr_len_dec u_dec_prim (
    .hw_i        (win_q[15:0]),
    .is_cinstr_o (prim_c)
  );

  assign aux_hw = prim_c ? win_q[31:16] : win_q[47:32];

  instr_len_dec u_dec_aux (
    .hw_i        (aux_hw),
    .is_cinstr_o (aux_c)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    p_len      = prim_c ? cnt_t'(1) : cnt_t'(2);
    a_len      = aux_c  ? cnt_t'(1) : cnt_t'(2);
    cancel     = (cnt_q < p_len);
    cancel_aux = cancel | (cnt_q < (p_len + a_len));
    k          = '0;
    if ((hold != HOLD) && !cancel) begin
      k = cancel_aux ? p_len : (p_len + a_len);
    end
    rem         = cnt_q - k;
    fetch_ready = !redirect && (rem <= cnt_t'(WIN_HW - FETCH_HW));
    accept      = fetch_valid && fetch_ready;
  end

  assign instr_addr_if       = pc_q;
  assign ifu_data_if         = win_q[XLEN-1:0];
  assign cancel_instr_if     = cancel     ? CANCEL_INSTR : ~CANCEL_INSTR;
  assign cancel_instr_if_aux = cancel_aux ? CANCEL_INSTR : ~CANCEL_INSTR;
  assign is_cinstr_if        = (filled_q && prim_c) ? IS_CINSTR : ~IS_CINSTR;
  assign is_cinstr_if_aux    = (filled_q && aux_c)  ? IS_CINSTR : ~IS_CINSTR;

  always_comb begin
    win_d    = win_q >> (16 * int'(k));
    cnt_d    = rem;
    pc_d     = pc_q + (ADDR'(k) << 1);
    drop_d   = drop_q;
    filled_d = filled_q | accept;
    if (accept) begin
      // Append the live halfwords right behind whatever survived the consume.
      for (int j = 0; j < FETCH_HW; j++) begin
        if (j >= int'(drop_q)) begin
          win_d[(int'(rem) + j - int'(drop_q)) * 16 +: 16] = fetch_data[j*16 +: 16];
        end
      end
      cnt_d  = rem + cnt_t'(FETCH_HW) - cnt_t'(drop_q);
      drop_d = '0;
    end
    if (redirect) begin
      win_d  = win_q;
      cnt_d  = '0;
      pc_d   = redirect_pc;
      drop_d = redirect_pc[2:1];
    end
  end

  // NOTE: the window is reset too, because ifu_data_if exposes it directly.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      win_q    <= '0;
      cnt_q    <= '0;
      pc_q     <= PC_RESET_ADDR;
      drop_q   <= PC_RESET_ADDR[2:1];
      filled_q <= 1'b0;
    end else begin
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
    end
  end

`ifndef SYNTHESIS
  a_cnt_bound : assert property (@(posedge clk) disable iff (!rstn)
    cnt_q <= cnt_t'(WIN_HW));
  a_append_fits : assert property (@(posedge clk) disable iff (!rstn)
    accept |-> (int'(rem) + FETCH_HW - int'(drop_q) <= WIN_HW));
`endif

endmodule

// File: tb/tb_instr_align_buffer.sv
// Directed bench for instr_align_buffer with hand-computed expected values.
module tb_instr_align_buffer;
  import instr_align_buffer_pkg::*;

  logic            clk = 1'b0;
  logic            rstn;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_data;
  logic            fetch_ready;
  logic            redirect;
  logic [ADDR-1:0] redirect_pc;
  logic            hold;
  logic [ADDR-1:0] instr_addr_if;
  logic [XLEN-1:0] ifu_data_if;
  logic            is_cinstr_if, is_cinstr_if_aux;
  logic            cancel_instr_if, cancel_instr_if_aux;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_align_buffer dut (
    .clk                 (clk),
    .rstn                (rstn),
    .fetch_valid         (fetch_valid),
    .fetch_data          (fetch_data),
    .fetch_ready         (fetch_ready),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .hold                (hold),
    .instr_addr_if       (instr_addr_if),
    .ifu_data_if         (ifu_data_if),
    .is_cinstr_if        (is_cinstr_if),
    .is_cinstr_if_aux    (is_cinstr_if_aux),
    .cancel_instr_if     (cancel_instr_if),
    .cancel_instr_if_aux (cancel_instr_if_aux)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply inputs shortly after a rising edge, then let combinational outputs settle.
  task automatic drive(input logic fv, input logic [XLEN-1:0] d, input logic h,
                       input logic rd, input logic [ADDR-1:0] rpc);
    fetch_valid = fv;
    fetch_data  = d;
    hold        = h;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cancels(input string tag, input logic c, input logic ca);
    check({tag, "_cancel"}, 64'(cancel_instr_if), 64'(c));
    check({tag, "_cancel_aux"}, 64'(cancel_instr_if_aux), 64'(ca));
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    step();
    step();
    rstn = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0);

    // Reset state
    check_cancels("rst", 1'b1, 1'b1);
    check("rst_pc", 64'(instr_addr_if), 64'h8000_0000);
    check("rst_ready", 64'(fetch_ready), 64'd1);
    check("rst_data", ifu_data_if, 64'h0);
    check("rst_isc", 64'({is_cinstr_if, is_cinstr_if_aux}), 64'd0);

    // Two 32-bit instructions in one word
    drive(1'b1, 64'h0000_0013_0000_0013, 1'b0, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    check_cancels("two32", 1'b0, 1'b0);
    check("two32_isc", 64'({is_cinstr_if, is_cinstr_if_aux}), 64'd0);
    check("two32_pc", 64'(instr_addr_if), 64'h8000_0000);
    check("two32_data", ifu_data_if, 64'h0000_0013_0000_0013);
    step();
    check("two32_pc_next", 64'(instr_addr_if), 64'h8000_0008);
    check_cancels("two32_empty", 1'b1, 1'b1);

    // Mixed: 16-bit 0x0001, 32-bit at hw1, trailing 16-bit at hw3
    drive(1'b1, 64'h0001_0000_0013_0001, 1'b0, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    check_cancels("mix", 1'b0, 1'b0);
    check("mix_isc", 64'(is_cinstr_if), 64'd1);
    check("mix_isc_aux", 64'(is_cinstr_if_aux), 64'd0);
    check("mix_pc", 64'(instr_addr_if), 64'h8000_0008);
    step();
    check("mix_pc_next", 64'(instr_addr_if), 64'h8000_000E);
    check_cancels("mix_tail", 1'b0, 1'b1);
    check("mix_tail_isc", 64'(is_cinstr_if), 64'd1);
    step();

    // Straddle: redirect to hw3 of a word holding the low half of a 32-bit instr
    drive(1'b0, '0, 1'b0, 1'b1, 32'h8000_0006);
    check("redir_ready", 64'(fetch_ready), 64'd0);
    step();
    drive(1'b1, 64'h0013_3333_2222_1111, 1'b0, 1'b0, '0);
    check_cancels("strad_empty", 1'b1, 1'b1);
    check("strad_pc0", 64'(instr_addr_if), 64'h8000_0006);
    step();
    drive(1'b1, 64'h0001_0001_0001_0000, 1'b0, 1'b0, '0);
    check_cancels("strad_half", 1'b1, 1'b1);
    check("strad_half_ready", 64'(fetch_ready), 64'd1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    check_cancels("strad_full", 1'b0, 1'b0);
    check("strad_pc", 64'(instr_addr_if), 64'h8000_0006);
    check("strad_data", 64'(ifu_data_if[31:0]), 64'h0000_0013);
    check("strad_isc", 64'({is_cinstr_if, is_cinstr_if_aux}), 64'b01);
    step();
    check("strad_pc_next", 64'(instr_addr_if), 64'h8000_000C);
    check_cancels("strad_rest", 1'b0, 1'b0);

    // Redirect concurrent with fetch_valid and hold: word must be dropped
    drive(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b1, 32'h8000_0100);
    check("rdh_ready", 64'(fetch_ready), 64'd0);
    step();
    drive(1'b1, 64'h000D_0009_0005_0001, 1'b1, 1'b0, '0);
    check_cancels("rdh_after", 1'b1, 1'b1);
    check("rdh_pc", 64'(instr_addr_if), 64'h8000_0100);

    // Fill to cnt=8 under hold, then hold three more cycles
    check("hold_a_ready", 64'(fetch_ready), 64'd1);
    step();
    drive(1'b1, 64'h0000_0013_0000_0013, 1'b1, 1'b0, '0);
    check("hold_b_ready", 64'(fetch_ready), 64'd1);
    check("hold_b_cancel", 64'(cancel_instr_if), 64'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, '0);
      check("hold_ready", 64'(fetch_ready), 64'd0);
      check("hold_pc", 64'(instr_addr_if), 64'h8000_0100);
      check("hold_data", ifu_data_if, 64'h000D_0009_0005_0001);
      step();
    end
    // Drain the full window
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    check("drain0_pc", 64'(instr_addr_if), 64'h8000_0100);
    check("drain0_isc", 64'({is_cinstr_if, is_cinstr_if_aux}), 64'b11);
    check("drain0_ready", 64'(fetch_ready), 64'd0);
    step();
    check("drain1_pc", 64'(instr_addr_if), 64'h8000_0104);
    check("drain1_data", 64'(ifu_data_if[31:0]), 64'h000D_0009);
    check("drain1_ready", 64'(fetch_ready), 64'd1);
    step();
    check("drain2_pc", 64'(instr_addr_if), 64'h8000_0108);
    check("drain2_data", ifu_data_if, 64'h0000_0013_0000_0013);
    check_cancels("drain2", 1'b0, 1'b0);
    check("drain2_isc", 64'({is_cinstr_if, is_cinstr_if_aux}), 64'b00);
    step();
    check("drain3_pc", 64'(instr_addr_if), 64'h8000_0110);
    check_cancels("drain3", 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
